// File: rtl/lrn_pkg.sv
// Shared LRN definitions: fill-state encoding and the padded-layout address helper.
// The mapper and the pad filler both compute addresses through pad_addr.
package lrn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } pad_state_t;

  localparam int unsigned LRN_IDX_W  = 32;
  localparam int unsigned LRN_CALC_W = 64;

  // Padded layout: n*(PW*PH*M) + m*(PW*PH) + w*PH + h, at full product width.
  function automatic logic [LRN_CALC_W-1:0] pad_addr(
    input logic [LRN_IDX_W-1:0] n,
    input logic [LRN_IDX_W-1:0] m,
    input logic [LRN_IDX_W-1:0] w,
    input logic [LRN_IDX_W-1:0] h,
    input logic [LRN_IDX_W-1:0] ph,
    input logic [LRN_IDX_W-1:0] pw,
    input logic [LRN_IDX_W-1:0] maps
  );
    logic [LRN_CALC_W-1:0] plane;
    plane = LRN_CALC_W'(pw) * LRN_CALC_W'(ph);
    return LRN_CALC_W'(n) * plane * LRN_CALC_W'(maps)
         + LRN_CALC_W'(m) * plane
         + LRN_CALC_W'(w) * LRN_CALC_W'(ph)
         + LRN_CALC_W'(h);
  endfunction

endpackage

// File: rtl/pad_idx_counter.sv
// 4-D border-position counter (h fastest, then w, m, n) that jumps over the
// interior of each column and flags the final border position.
module pad_idx_counter
  import lrn_pkg::*;
#(
  parameter int N_WIDTH = 2,
  parameter int M_WIDTH = 10,
  parameter int E_WIDTH = 6,
  parameter int F_WIDTH = 6,
  parameter int V_WIDTH = 2
) (
  input  logic               core_clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [V_WIDTH-1:0] pad_i,
  input  logic [F_WIDTH-1:0] dim1_i,
  input  logic [E_WIDTH-1:0] dim2_i,
  input  logic [M_WIDTH-1:0] dim3_i,
  input  logic [N_WIDTH-1:0] dim4_i,
  input  logic [E_WIDTH:0]   ph_i,
  input  logic [F_WIDTH:0]   pw_i,
  output logic [E_WIDTH:0]   h_step_o,
  output logic [F_WIDTH:0]   w_step_o,
  output logic [M_WIDTH-1:0] m_step_o,
  output logic [N_WIDTH-1:0] n_step_o,
  output logic               last_o
);

  localparam int EW = E_WIDTH + 1;
  localparam int FW = F_WIDTH + 1;

  logic [EW-1:0]      h_q, h_d, h_step_s;
  logic [FW-1:0]      w_q, w_d, w_step_s;
  logic [M_WIDTH-1:0] m_q, m_d, m_step_s;
  logic [N_WIDTH-1:0] n_q, n_d, n_step_s;
  logic [EW-1:0]      pad_e_s;
  logic [FW-1:0]      pad_f_s;
  logic               interior_col_s;
  logic               h_end_s, w_end_s, m_end_s, n_end_s;

  assign pad_e_s        = EW'(pad_i);
  assign pad_f_s        = FW'(pad_i);
  assign interior_col_s = (w_q >= pad_f_s) && (w_q < (pad_f_s + {1'b0, dim1_i}));
  assign h_end_s        = (h_q == (ph_i - EW'(1)));
  assign w_end_s        = (w_q == (pw_i - FW'(1)));
  assign m_end_s        = (m_q == (dim3_i - M_WIDTH'(1)));
  assign n_end_s        = (n_q == (dim4_i - N_WIDTH'(1)));
  assign last_o         = h_end_s && w_end_s && m_end_s && n_end_s;

  // Successor of the current position; interior rows are never visited.
  always_comb begin
    h_step_s = h_q + EW'(1);
    w_step_s = w_q;
    m_step_s = m_q;
    n_step_s = n_q;
    if (h_end_s) begin
      h_step_s = '0;
      if (w_end_s) begin
        w_step_s = '0;
        if (m_end_s) begin
          m_step_s = '0;
          n_step_s = n_q + N_WIDTH'(1);
        end else begin
          m_step_s = m_q + M_WIDTH'(1);
        end
      end else begin
        w_step_s = w_q + FW'(1);
      end
    end else if (interior_col_s && ((h_q + EW'(1)) == pad_e_s)) begin
      h_step_s = pad_e_s + {1'b0, dim2_i};
    end else begin
      h_step_s = h_q + EW'(1);
    end
  end

  // Load clears to origin; otherwise step only on an accepted write.
  always_comb begin
    h_d = h_q;
    w_d = w_q;
    m_d = m_q;
    n_d = n_q;
    if (load_i) begin
      h_d = '0;
      w_d = '0;
      m_d = '0;
      n_d = '0;
    end else if (advance_i) begin
      h_d = h_step_s;
      w_d = w_step_s;
      m_d = m_step_s;
      n_d = n_step_s;
    end else begin
      h_d = h_q;
    end
  end

  // Index registers.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      w_q <= '0;
      m_q <= '0;
      n_q <= '0;
    end else begin
      h_q <= h_d;
      w_q <= w_d;
      m_q <= m_d;
      n_q <= n_d;
    end
  end

  assign h_step_o = h_step_s;
  assign w_step_o = w_step_s;
  assign m_step_o = m_step_s;
  assign n_step_o = n_step_s;

endmodule

// File: rtl/pad_filler.sv
// Writes zeros to every border position of a padded LRN layer after start_padding.
// Optional PAD_BACKPRESSURE_EN adds w_ready and stalls writes while it is low.
module pad_filler
  import lrn_pkg::*;
#(
  parameter int N_WIDTH        = 2,
  parameter int M_WIDTH        = 10,
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int V_WIDTH        = 2,
  parameter int ADDR_BUS_WIDTH = 20,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      start_padding,
  input  logic [N_WIDTH-1:0]        dim4,
  input  logic [M_WIDTH-1:0]        dim3,
  input  logic [E_WIDTH-1:0]        dim2,
  input  logic [F_WIDTH-1:0]        dim1,
  input  logic [V_WIDTH-1:0]        padding_num,
`ifdef PAD_BACKPRESSURE_EN
  input  logic                      w_ready,
`endif
  output logic [ADDR_BUS_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0]     w_data,
  output logic                      w_enable,
  output logic                      busy,
  output logic                      pad_done
);

  localparam int EW = E_WIDTH + 1;
  localparam int FW = F_WIDTH + 1;

  pad_state_t              state_q, state_d;
  logic [F_WIDTH-1:0]      dim1_q;
  logic [E_WIDTH-1:0]      dim2_q;
  logic [M_WIDTH-1:0]      dim3_q;
  logic [N_WIDTH-1:0]      dim4_q;
  logic [V_WIDTH-1:0]      pad_q;
  logic [EW-1:0]           ph_q, ph_in_s;
  logic [FW-1:0]           pw_q, pw_in_s;
  logic                    w_enable_q, w_enable_d;
  logic [ADDR_BUS_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic                    busy_q, pad_done_q;
  logic                    empty_in_s, accept_s, cfg_load_s, load_s, advance_s, last_s;
  logic [EW-1:0]           h_step_s;
  logic [FW-1:0]           w_step_s;
  logic [M_WIDTH-1:0]      m_step_s;
  logic [N_WIDTH-1:0]      n_step_s;

  assign ph_in_s    = {1'b0, dim2} + (EW'(padding_num) << 1);
  assign pw_in_s    = {1'b0, dim1} + (FW'(padding_num) << 1);
  assign empty_in_s = (padding_num == '0) || (dim1 == '0) || (dim2 == '0)
                   || (dim3 == '0) || (dim4 == '0);
  assign cfg_load_s = (state_q == IDLE) && start_padding;

`ifdef PAD_BACKPRESSURE_EN
  assign accept_s = w_enable_q && w_ready;
`else
  assign accept_s = w_enable_q;
`endif

  pad_idx_counter #(
    .N_WIDTH (N_WIDTH),
    .M_WIDTH (M_WIDTH),
    .E_WIDTH (E_WIDTH),
    .F_WIDTH (F_WIDTH),
    .V_WIDTH (V_WIDTH)
  ) u_idx (
    .core_clk  (core_clk),
    .reset     (reset),
    .load_i    (load_s),
    .advance_i (advance_s),
    .pad_i     (pad_q),
    .dim1_i    (dim1_q),
    .dim2_i    (dim2_q),
    .dim3_i    (dim3_q),
    .dim4_i    (dim4_q),
    .ph_i      (ph_q),
    .pw_i      (pw_q),
    .h_step_o  (h_step_s),
    .w_step_o  (w_step_s),
    .m_step_o  (m_step_s),
    .n_step_o  (n_step_s),
    .last_o    (last_s)
  );

  // Next state and next write; the write register always holds the position
  // the counter currently points at, so it is refreshed from the successor.
  always_comb begin
    state_d    = state_q;
    w_enable_d = w_enable_q;
    w_addr_d   = w_addr_q;
    load_s     = 1'b0;
    advance_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_padding) begin
          state_d    = FILL;
          load_s     = 1'b1;
          w_enable_d = !empty_in_s;
          w_addr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (!w_enable_q) begin
          state_d = DONE;
        end else if (accept_s && last_s) begin
          state_d    = DONE;
          w_enable_d = 1'b0;
        end else if (accept_s) begin
          advance_s = 1'b1;
          w_addr_d  = ADDR_BUS_WIDTH'(pad_addr(LRN_IDX_W'(n_step_s), LRN_IDX_W'(m_step_s),
                                               LRN_IDX_W'(w_step_s), LRN_IDX_W'(h_step_s),
                                               LRN_IDX_W'(ph_q), LRN_IDX_W'(pw_q),
                                               LRN_IDX_W'(dim3_q)));
        end else begin
          state_d = FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      pad_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_enable_q <= w_enable_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= '0;
      busy_q     <= (state_d != IDLE);
      pad_done_q <= (state_d == DONE);
    end
  end

  // Geometry captured once per fill so later input changes are ignored.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      dim1_q <= '0;
      dim2_q <= '0;
      dim3_q <= '0;
      dim4_q <= '0;
      pad_q  <= '0;
      ph_q   <= '0;
      pw_q   <= '0;
    end else if (cfg_load_s) begin
      dim1_q <= dim1;
      dim2_q <= dim2;
      dim3_q <= dim3;
      dim4_q <= dim4;
      pad_q  <= padding_num;
      ph_q   <= ph_in_s;
      pw_q   <= pw_in_s;
    end
  end

  assign w_enable = w_enable_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign busy     = busy_q;
  assign pad_done = pad_done_q;

endmodule

// File: tb/tb_pad_filler.sv
// Self-checking bench for pad_filler: table of fill geometries plus hand-written
// corner sequences, with expected write addresses queued as a scoreboard.
module tb_pad_filler;

  logic        core_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        start_padding = 1'b0;
  logic [1:0]  dim4 = '0;
  logic [9:0]  dim3 = '0;
  logic [5:0]  dim2 = '0;
  logic [5:0]  dim1 = '0;
  logic [1:0]  padding_num = '0;
  logic        rdy = 1'b1;
  logic [19:0] w_addr;
  logic [15:0] w_data;
  logic        w_enable, busy, pad_done;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  typedef struct {
    int d4, d3, d2, d1, p, writes;
  } vec_t;
  vec_t vecs[6];

  always #5 core_clk = ~core_clk;

  pad_filler dut (
    .core_clk      (core_clk),
    .reset         (reset),
    .start_padding (start_padding),
    .dim4          (dim4),
    .dim3          (dim3),
    .dim2          (dim2),
    .dim1          (dim1),
    .padding_num   (padding_num),
`ifdef PAD_BACKPRESSURE_EN
    .w_ready       (rdy),
`endif
    .w_addr        (w_addr),
    .w_data        (w_data),
    .w_enable      (w_enable),
    .busy          (busy),
    .pad_done      (pad_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: visit every padded position in scan order, keep the border ones.
  task automatic push_model(input int d4, d3, d2, d1, p);
    int ph, pw;
    if (p == 0 || d1 == 0 || d2 == 0 || d3 == 0 || d4 == 0) return;
    ph = d2 + 2 * p;
    pw = d1 + 2 * p;
    for (int n = 0; n < d4; n++)
      for (int m = 0; m < d3; m++)
        for (int w = 0; w < pw; w++)
          for (int h = 0; h < ph; h++)
            if (h < p || h >= p + d2 || w < p || w >= p + d1)
              exp_q.push_back(n * pw * ph * d3 + m * pw * ph + w * ph + h);
  endtask

  // One fill: drive start, score writes as they appear, check completion timing.
  task automatic run_fill(input string tag, input int d4, d3, d2, d1, p,
                          input int exp_writes, input int exp_done,
                          input int restart_at, input int stall_at);
    int writes = 0;
    int done_cyc = -1;
    @(negedge core_clk);
    dim4 = 2'(d4); dim3 = 10'(d3); dim2 = 6'(d2); dim1 = 6'(d1);
    padding_num = 2'(p);
    start_padding = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge core_clk);
      start_padding = (cyc == restart_at);
      if (cyc == 1) begin
        check({tag, " busy"}, longint'(busy), 1);
        dim4 = 2'd3; dim3 = 10'd7; dim2 = 6'd9; dim1 = 6'd5; padding_num = 2'd3;
      end
      rdy = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3);
      if (w_enable) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra write"}, longint'(w_addr), -1);
        end else if (rdy) begin
          writes++;
          check({tag, " addr"}, longint'(w_addr), longint'(exp_q.pop_front()));
          check({tag, " data"}, longint'(w_data), 0);
        end else begin
          check({tag, " held addr"}, longint'(w_addr), longint'(exp_q[0]));
        end
      end
      if (pad_done) begin
        done_cyc = cyc;
        break;
      end
    end
    rdy = 1'b1;
    check({tag, " done cycle"}, longint'(done_cyc), longint'(exp_done));
    check({tag, " write count"}, longint'(writes), longint'(exp_writes));
    check({tag, " leftover"}, longint'(exp_q.size()), 0);
    @(negedge core_clk);
    check({tag, " done width"}, longint'(pad_done), 0);
    check({tag, " idle busy"}, longint'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    int basic_exp[12] = '{0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15};

    vecs[0] = '{d4: 1, d3: 1, d2: 2, d1: 2, p: 1, writes: 12};
    vecs[1] = '{d4: 1, d3: 1, d2: 2, d1: 2, p: 0, writes: 0};
    vecs[2] = '{d4: 2, d3: 3, d2: 3, d1: 3, p: 2, writes: 240};
    vecs[3] = '{d4: 1, d3: 2, d2: 1, d1: 3, p: 3, writes: 120};
    vecs[4] = '{d4: 1, d3: 1, d2: 0, d1: 2, p: 1, writes: 0};
    vecs[5] = '{d4: 3, d3: 1, d2: 1, d1: 1, p: 1, writes: 24};

    @(negedge core_clk);
    check("reset w_enable", longint'(w_enable), 0);
    check("reset w_addr", longint'(w_addr), 0);
    check("reset busy", longint'(busy), 0);
    check("reset pad_done", longint'(pad_done), 0);
    @(negedge core_clk);
    reset = 1'b0;

    // Basic fill against the hand-derived address list.
    foreach (basic_exp[i]) exp_q.push_back(basic_exp[i]);
    run_fill("basic", 1, 1, 2, 2, 1, 12, 13, 0, 0);

    for (int i = 0; i < 6; i++) begin
      push_model(vecs[i].d4, vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].p);
      check($sformatf("vec%0d model count", i), longint'(exp_q.size()),
            longint'(vecs[i].writes));
      run_fill($sformatf("vec%0d", i), vecs[i].d4, vecs[i].d3, vecs[i].d2,
               vecs[i].d1, vecs[i].p, vecs[i].writes,
               (vecs[i].writes == 0) ? 2 : vecs[i].writes + 1, 0, 0);
    end

    // Restart pulse while busy is ignored.
    push_model(1, 1, 2, 2, 1);
    run_fill("restart", 1, 1, 2, 2, 1, 12, 13, 4, 0);

`ifdef PAD_BACKPRESSURE_EN
    push_model(1, 1, 2, 2, 1);
    run_fill("stall", 1, 1, 2, 2, 1, 12, 16, 0, 5);
`endif

    // Reset after five writes abandons the fill.
    push_model(1, 1, 2, 2, 1);
    @(negedge core_clk);
    dim4 = 2'd1; dim3 = 10'd1; dim2 = 6'd2; dim1 = 6'd2; padding_num = 2'd1;
    start_padding = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge core_clk);
      start_padding = 1'b0;
      check("pre-reset w_enable", longint'(w_enable), 1);
      check("pre-reset addr", longint'(w_addr), longint'(exp_q.pop_front()));
    end
    reset = 1'b1;
    @(negedge core_clk);
    check("mid reset w_enable", longint'(w_enable), 0);
    check("mid reset w_addr", longint'(w_addr), 0);
    check("mid reset w_data", longint'(w_data), 0);
    check("mid reset busy", longint'(busy), 0);
    check("mid reset pad_done", longint'(pad_done), 0);
    reset = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge core_clk);
      check("post reset pad_done", longint'(pad_done), 0);
    end
    exp_q.delete();
    foreach (basic_exp[i]) exp_q.push_back(basic_exp[i]);
    run_fill("after reset", 1, 1, 2, 2, 1, 12, 13, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
